// File: rtl/pipeline_stall_controller_pkg.sv
// Purpose: shared pipeline encodings for the stall/flush controller and its helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_stall_controller_pkg;

    // Register-index width of the RV32I register file
    localparam int REG_W = 5;

    // Canonical NOP (addi x0, x0, 0) loaded into IF/ID on a flush
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Sequencer states; encodings are shared with the rest of the pipeline
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_stall_controller_load_use_detect.sv
// Purpose: flags a load in EX whose destination feeds the instruction in ID.
// Latency: purely combinational, same-cycle hazard.
// Backpressure: none; the caller turns the hazard into a one-cycle stall.
module load_use_detect
    import pipeline_stall_controller_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    output logic             hazard
);

    // x0 is never a real dependency; rs2 only matters when ID actually reads it
    always_comb begin
        hazard = ex_mem_read && (ex_rd != '0) &&
                 ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Purpose: central stall/flush sequencer (load-use, branch redirect, data-memory wait).
// Latency: enables/flushes are combinational from state + inputs; counters lag one cycle.
// Backpressure: a pending memory access freezes every pipeline register until mem_ready.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_enable,
    output logic             mem_wb_enable,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int                WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d, wait_cur;
    logic [CNT_W-1:0]  stall_cycles_q, flush_count_q;
    logic              lu_hazard;
    logic              freeze;

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .hazard      (lu_hazard)
    );

    // Next state: the first frozen cycle in RUN counts as wait cycle 0, so ERROR is
    // entered after exactly MEM_TIMEOUT consecutive frozen cycles
    always_comb begin
        freeze     = ((state_q == ST_RUN) && mem_req && !mem_ready) ||
                     ((state_q == ST_MEM_WAIT) && !mem_ready);
        wait_cur   = (state_q == ST_MEM_WAIT) ? wait_cnt_q : '0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (freeze) begin
                    if (wait_cur == WAIT_LAST) begin
                        state_d    = ST_ERROR;
                        wait_cnt_d = '0;
                    end else begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = wait_cur + 1'b1;
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            ST_ERROR: begin
                state_d    = ST_ERROR;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Enables/flushes by priority: ERROR > memory freeze > load-use > branch; reset forces run values
    always_comb begin
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_enable = 1'b1;
        mem_wb_enable = 1'b1;
        mem_error     = 1'b0;
        if (reset) begin
            mem_error = 1'b0;
        end else if (state_q == ST_ERROR) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
            mem_error     = 1'b1;
        end else if (freeze) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
        end else if (lu_hazard) begin
            // Branch operands are not valid yet, so a concurrent redirect is ignored
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_flush  = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
        end
    end

    // State, wait counter and saturating performance counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (!pc_enable && (stall_cycles_q != CNT_MAX)) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
            if (if_id_flush && (flush_count_q != CNT_MAX)) begin
                flush_count_q <= flush_count_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Purpose: directed scoreboard bench for pipeline_stall_controller (MEM_TIMEOUT=4, CNT_W=3).
// Latency: expectations are checked mid-cycle, after inputs settle.
// Backpressure: n/a.
module tb_pipeline_stall_controller;

    localparam int CNT_W = 3;

    // Expected output vector: {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en, mem_error}
    localparam logic [6:0] ALL_EN = 7'b1100110;
    localparam logic [6:0] LU     = 7'b0001110;
    localparam logic [6:0] BR     = 7'b1110110;
    localparam logic [6:0] FRZ    = 7'b0000000;
    localparam logic [6:0] ERR    = 7'b0000001;

    typedef struct {
        string      tag;
        logic [6:0] outs;
        int         stall;
        int         flush;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs2, ex_mem_read, branch_taken, mem_req, mem_ready;
    logic             pc_enable, if_id_enable, if_id_flush, id_ex_flush;
    logic             ex_mem_enable, mem_wb_enable, mem_error;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs2   (id_uses_rs2),
        .ex_rd         (ex_rd),
        .ex_mem_read   (ex_mem_read),
        .branch_taken  (branch_taken),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .pc_enable     (pc_enable),
        .if_id_enable  (if_id_enable),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_enable (ex_mem_enable),
        .mem_wb_enable (mem_wb_enable),
        .mem_error     (mem_error),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    // Monitor: every cycle that has a pending expectation is compared on the falling edge
    initial begin
        logic [6:0] got;
        exp_t       e;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {pc_enable, if_id_enable, if_id_flush, id_ex_flush,
                       ex_mem_enable, mem_wb_enable, mem_error};
                checks++;
                if (got !== e.outs) begin
                    errors++;
                    $display("FAIL %s outs: got %b want %b", e.tag, got, e.outs);
                end
                checks++;
                if (int'(stall_cycles) != e.stall) begin
                    errors++;
                    $display("FAIL %s stall_cycles: got %0d want %0d", e.tag, stall_cycles, e.stall);
                end
                checks++;
                if (int'(flush_count) != e.flush) begin
                    errors++;
                    $display("FAIL %s flush_count: got %0d want %0d", e.tag, flush_count, e.flush);
                end
            end
        end
    end

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic mr, input logic br,
                          input logic mq, input logic my);
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_uses_rs2  = u2;
        ex_rd        = rd;
        ex_mem_read  = mr;
        branch_taken = br;
        mem_req      = mq;
        mem_ready    = my;
    endtask

    // Inputs are already applied for this cycle; queue its expectation and advance
    task automatic cyc(input string tag, input logic [6:0] o, input int s, input int f);
        exp_t e;
        e.tag   = tag;
        e.outs  = o;
        e.stall = s;
        e.flush = f;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed vectors, expectations worked out by hand
    initial begin
        reset = 1'b1;
        set_in(5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        // Load-use present while in reset must not show through
        for (int i = 0; i < 3; i++) cyc("reset_hold", ALL_EN, 0, 0);
        reset = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("reset_idle", ALL_EN, 0, 0);

        set_in(5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_rs1", LU, 0, 0);
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lu_release", ALL_EN, 1, 0);
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_rd_x0", ALL_EN, 1, 0);
        set_in(5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_rs2_unused", ALL_EN, 1, 0);
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("branch", BR, 1, 0);
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("branch_after", ALL_EN, 1, 1);
        set_in(5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("lu_rs2_over_branch", LU, 1, 1);
        set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("ex_not_load", ALL_EN, 2, 1);
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("mem_single_cycle", ALL_EN, 2, 1);

        // Three-cycle memory wait; a branch/load-use during the freeze is overridden
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("mem_wait_1", FRZ, 2, 1);
        set_in(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("mem_wait_2", FRZ, 3, 1);
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("mem_wait_3", FRZ, 4, 1);
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc("mem_ready_branch", BR, 5, 1);
        // mem_ready low with no request: only a RUN state lets this through
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("back_in_run", ALL_EN, 5, 2);

        // Timeout after four frozen cycles; stall counter saturates at 7
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("timeout_1", FRZ, 5, 2);
        cyc("timeout_2", FRZ, 6, 2);
        cyc("timeout_3", FRZ, 7, 2);
        cyc("timeout_4", FRZ, 7, 2);
        cyc("error", ERR, 7, 2);
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc("error_sticky", ERR, 7, 2);
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("error_saturated", ERR, 7, 2);

        // Asynchronous reset in ERROR takes effect before the next clock edge
        reset = 1'b1;
        cyc("reset_in_error", ALL_EN, 0, 0);
        reset = 1'b0;
        cyc("run_after_error", ALL_EN, 0, 0);

        // Reset while in MEM_WAIT returns to RUN
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("wait_enter", FRZ, 0, 0);
        cyc("wait_hold", FRZ, 1, 0);
        reset = 1'b1;
        cyc("reset_in_wait", ALL_EN, 0, 0);
        reset = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("run_after_wait", ALL_EN, 0, 0);

        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
